// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, counter debouncer,
// press/release edge pulses and per-channel hold-to-repeat pulse generation.
module button_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic             clk_100M,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax);

    localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        StReleased,
        StHold,
        StRepeat
    } state_e;

    logic [N_BTN-1:0] meta_q;
    logic [N_BTN-1:0] sync_q;

    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] repeat_q, repeat_d;

    logic [DbW-1:0]  db_cnt_q  [N_BTN];
    logic [DbW-1:0]  db_cnt_d  [N_BTN];
    logic [RepW-1:0] rep_cnt_q [N_BTN];
    logic [RepW-1:0] rep_cnt_d [N_BTN];
    state_e          state_q   [N_BTN];
    state_e          state_d   [N_BTN];

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i]  = db_cnt_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            state_d[i]   = state_q[i];

            // Any sample matching the current level restarts the stability window.
            if (sync_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                db_cnt_d[i]  = '0;
                level_d[i]   = sync_q[i];
                press_d[i]   = sync_q[i];
                release_d[i] = ~sync_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end

            unique case (state_q[i])
                StReleased: begin
                    if (press_d[i]) begin
                        state_d[i]   = StHold;
                        rep_cnt_d[i] = '0;
                    end
                end
                StHold: begin
                    if (release_d[i]) begin
                        state_d[i]   = StReleased;
                        rep_cnt_d[i] = '0;
                    end else if (!repeat_en[i]) begin
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == DelayLast) begin
                        repeat_d[i]  = 1'b1;
                        state_d[i]   = StRepeat;
                        rep_cnt_d[i] = '0;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
                    end
                end
                StRepeat: begin
                    // Release wins over a coinciding repeat terminal count.
                    if (release_d[i]) begin
                        state_d[i]   = StReleased;
                        rep_cnt_d[i] = '0;
                    end else if (!repeat_en[i]) begin
                        state_d[i]   = StHold;
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == PeriodLast) begin
                        repeat_d[i]  = 1'b1;
                        rep_cnt_d[i] = '0;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
                    end
                end
                default: begin
                    state_d[i]   = StReleased;
                    rep_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100M or negedge reset) begin
        if (!reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]  <= '0;
                rep_cnt_q[i] <= '0;
                state_q[i]   <= StReleased;
            end
        end else begin
            meta_q    <= btn_raw;
            sync_q    <= meta_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable-input cycles before a level change is accepted (10 ms at 100 MHz), minimum 2.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000: held cycles before the first auto-repeat pulse (0.5 s), minimum 2.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses (0.1 s), minimum 2.
REQ-005 SHALL have port clk_100M, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port btn_raw, input, N_BTN: asynchronous raw button levels (bit0=btnU, bit1=btnL, bit2=btnR, bit3=btnD in top), 1 = pressed.
REQ-008 SHALL have port repeat_en, input, N_BTN: per-channel auto-repeat enable.
REQ-009 SHALL have port btn_level, output, N_BTN: debounced level.
REQ-010 SHALL have port btn_press, output, N_BTN: one-cycle pulse on accepted 0->1.
REQ-011 SHALL have port btn_release, output, N_BTN: one-cycle pulse on accepted 1->0.
REQ-012 SHALL have port btn_repeat, output, N_BTN: one-cycle auto-repeat pulse.

Function
REQ-013 SHALL pass each btn_raw bit through a 2-flop synchronizer; s[i] = btn_raw[i] delayed 2 clocks.
REQ-014 SHALL keep per channel a counter of width $clog2(DEBOUNCE_CYCLES): cleared when s[i]==btn_level[i], incremented when s[i]!=btn_level[i].
REQ-015 SHALL, on the edge where the counter equals DEBOUNCE_CYCLES-1 and s[i]!=btn_level[i], set btn_level[i]<=s[i], clear the counter, and assert btn_press[i] or btn_release[i] for exactly that next cycle.
REQ-016 SHALL restart debouncing from zero on any glitch: a bounce shorter than DEBOUNCE_CYCLES produces no level change and no pulse.
REQ-017 SHALL give press latency of exactly DEBOUNCE_CYCLES+2 cycles from the first clock edge sampling a clean raw change to the asserted pulse edge; release latency SHALL be identical.
REQ-018 SHALL run per channel an FSM with states RELEASED, HOLD, REPEAT; RELEASED->HOLD on accepted press; HOLD/REPEAT->RELEASED on accepted release.
REQ-019 SHALL in HOLD count held cycles from the press pulse; when repeat_en[i]=1 and count reaches REPEAT_DELAY-1, pulse btn_repeat[i] and go to REPEAT with count cleared.
REQ-020 SHALL in REPEAT pulse btn_repeat[i] every REPEAT_PERIOD cycles while repeat_en[i]=1.
REQ-021 SHALL, when repeat_en[i] drops, stop repeat pulses immediately, return to HOLD, and clear the hold counter; re-assertion restarts the REPEAT_DELAY wait.
REQ-022 SHALL never assert btn_repeat[i] in the same cycle as btn_press[i] or btn_release[i]; a release coinciding with a repeat terminal count SHALL produce only btn_release.
REQ-023 SHALL treat channels fully independently; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-024 SHALL saturate no counter silently: hold/repeat counter width SHALL be $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)) and SHALL wrap only via explicit clear.

Reset
REQ-025 SHALL, while reset=0, force synchronizers, counters and btn_level to 0, all FSMs to RELEASED, and btn_press/btn_release/btn_repeat to 0, asynchronously.
REQ-026 SHALL, on reset assertion mid-debounce or mid-repeat, discard pending state; a button held through reset release SHALL produce a press pulse DEBOUNCE_CYCLES+2 cycles after reset deasserts.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_BTN=4)
REQ-027 SHALL verify clean press: btn_raw[1] 0->1 held -> btn_press[1] single pulse 10 cycles later, btn_level[1]=1, other outputs 0.
REQ-028 SHALL verify bounce: btn_raw[0] toggles high 5 cycles, low 2, high held -> exactly one btn_press[0], 10 cycles after final rise.
REQ-029 SHALL verify auto-repeat: repeat_en[2]=1, btn_raw[2] held 60 cycles -> press pulse, repeat pulses at +20, +25, +30, ... relative to press, then one release pulse.
REQ-030 SHALL verify repeat disable: repeat_en[2] dropped mid-REPEAT -> no further btn_repeat[2]; re-enable -> next pulse 20 cycles later.
REQ-031 SHALL verify simultaneous: btn_raw=4'b1111 in one cycle -> btn_press=4'b1111 in one cycle; release all -> btn_release=4'b1111.
REQ-032 SHALL verify reset mid-hold: reset=0 for 3 cycles while btn_raw[3]=1 -> all outputs 0 at once; press pulse 10 cycles after reset=1.
